// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: byte memory port, redirect input and
// decoder-facing instruction handshake.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [15:0]           instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_out,
    output instr_pc
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_out,
    input  instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: assembles big-endian 16-bit words from two byte
// reads, buffers them and hands them to the decoder.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {S_HI, S_LO, S_DRAIN} state_t;

  localparam addr_t ONE = addr_t'(1);

  state_t        state;
  addr_t         fetch_pc;
  addr_t         drain_addr;
  logic [7:0]    hi_byte;
  logic [15:0]   word_q [FIFO_DEPTH];
  addr_t         pc_q   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic req;
  logic fire;
  logic push;
  logic pop;
  logic valid;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A word is only started when a slot is free, so S_LO never stalls
  always_comb begin
    req = 1'b0;
    if (!reset)
      req = (state != S_HI) || (count < CW'(FIFO_DEPTH));
  end

  assign fire  = req && bus.mem_ack;
  assign push  = fire && (state == S_LO) && !bus.redirect_valid;
  assign valid = !reset && (count != '0);
  assign pop   = valid && bus.instr_ready && !bus.redirect_valid;

  assign bus.mem_req     = req;
  assign bus.mem_addr    = (state == S_DRAIN) ? drain_addr : fetch_pc;
  assign bus.instr_valid = valid;
  assign bus.instr_out   = reset ? '0 : word_q[rd_ptr];
  assign bus.instr_pc    = reset ? '0 : pc_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HI;
      fetch_pc   <= RESET_PC;
      drain_addr <= '0;
      hi_byte    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // An unacked request must still complete before refetching
      unique case (1'b1)
        (state == S_DRAIN):
          state <= bus.mem_ack ? S_HI : S_DRAIN;
        (state != S_DRAIN) && req && !bus.mem_ack: begin
          drain_addr <= bus.mem_addr;
          state      <= S_DRAIN;
        end
        default:
          state <= S_HI;
      endcase
    end else begin
      unique case (state)
        S_HI:
          if (fire) begin
            hi_byte  <= bus.mem_rdata;
            fetch_pc <= fetch_pc + ONE;
            state    <= S_LO;
          end
        S_LO:
          if (fire) begin
            word_q[wr_ptr] <= {hi_byte, bus.mem_rdata};
            pc_q[wr_ptr]   <= fetch_pc - ONE;
            wr_ptr         <= nxt(wr_ptr);
            fetch_pc       <= fetch_pc + ONE;
            state          <= S_HI;
          end
        S_DRAIN:
          if (fire) state <= S_HI;
        default:
          state <= S_HI;
      endcase
      if (pop) rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte-memory responder
// and per-DUT expected-word scoreboards.
module tb_instr_fetch_unit;
  logic tb_clk = 1'b0;
  logic reset;

  always #5 tb_clk = ~tb_clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(16)) f0 ();
  instr_fetch_unit_if #(.ADDR_WIDTH(16)) f1 ();

  instr_fetch_unit #(
    .ADDR_WIDTH(16), .RESET_PC(16'h0000), .FIFO_DEPTH(2)
  ) dut0 (
    .clk(tb_clk), .reset(reset), .bus(f0)
  );

  instr_fetch_unit #(
    .ADDR_WIDTH(16), .RESET_PC(16'hFFFF), .FIFO_DEPTH(2)
  ) dut1 (
    .clk(tb_clk), .reset(reset), .bus(f1)
  );

  int checks = 0;
  int errors = 0;
  int waits0 = 0;
  int wc0 = 0;
  int wc1 = 0;
  int ack_cnt0 = 0;
  logic [15:0] ack_log0 [$];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  function automatic logic [7:0] byte_at(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h12;
      16'h0001: return 8'h34;
      16'h0002: return 8'h56;
      16'h0003: return 8'h78;
      default:  return (a[7:0] + 8'h3B) ^ a[15:8];
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [15:0] p);
    logic [15:0] p1;
    p1 = p + 16'd1;
    return {p, byte_at(p), byte_at(p1)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responders: ack after waitsN idle cycles per request
  always @(negedge tb_clk) begin
    if (reset || !f0.mem_req) begin
      f0.mem_ack = 1'b0;
      wc0 = 0;
    end else if (wc0 >= waits0) begin
      f0.mem_ack   = 1'b1;
      f0.mem_rdata = byte_at(f0.mem_addr);
      wc0 = 0;
      ack_cnt0++;
      ack_log0.push_back(f0.mem_addr);
    end else begin
      f0.mem_ack = 1'b0;
      wc0++;
    end
  end

  always @(negedge tb_clk) begin
    if (reset || !f1.mem_req) begin
      f1.mem_ack = 1'b0;
      wc1 = 0;
    end else begin
      f1.mem_ack   = 1'b1;
      f1.mem_rdata = byte_at(f1.mem_addr);
    end
  end

  always @(negedge tb_clk) begin
    if (!reset && f0.instr_valid && f0.instr_ready &&
        !f0.redirect_valid && q0.size() > 0)
      chk("sb0", {f0.instr_pc, f0.instr_out}, q0.pop_front());
  end

  always @(negedge tb_clk) begin
    if (!reset && f1.instr_valid && f1.instr_ready &&
        !f1.redirect_valid && q1.size() > 0)
      chk("sb1", {f1.instr_pc, f1.instr_out}, q1.pop_front());
  end

  task automatic edge_drive();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f0.redirect_valid = 1'b0;
    f1.redirect_valid = 1'b0;
    repeat (2) edge_drive();
    q0.delete();
    q1.delete();
    ack_log0.delete();
    ack_cnt0 = 0;
    reset = 1'b0;
  endtask

  task automatic drain(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
      edge_drive();
      n++;
    end
    chk((which == 0) ? "drain0" : "drain1",
        (which == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    f0.redirect_valid = 1'b0;
    f0.redirect_pc = '0;
    f0.instr_ready = 1'b1;
    f1.redirect_valid = 1'b0;
    f1.redirect_pc = '0;
    f1.instr_ready = 1'b1;

    // 1: zero-wait fetch latency and byte order
    waits0 = 0;
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(exp_word(16'(2 * i)));
    @(negedge tb_clk);
    chk("t1_req_c0", 32'(f0.mem_req), 1);
    chk("t1_addr_c0", 32'(f0.mem_addr), 32'h0000);
    @(negedge tb_clk);
    chk("t1_addr_c1", 32'(f0.mem_addr), 32'h0001);
    chk("t1_valid_c1", 32'(f0.instr_valid), 0);
    @(negedge tb_clk);
    chk("t1_valid_c2", 32'(f0.instr_valid), 1);
    chk("t1_word_c2", {f0.instr_pc, f0.instr_out}, 32'h0000_1234);
    @(negedge tb_clk);
    chk("t1_valid_c3", 32'(f0.instr_valid), 0);
    @(negedge tb_clk);
    chk("t1_word_c4", {f0.instr_pc, f0.instr_out}, 32'h0002_5678);
    drain(0, 20);
    for (int i = 0; i < 4; i++)
      chk("t1_addr_seq", 32'(ack_log0[i]), i);

    // 2: backpressure fills the buffer then stops requesting
    f0.instr_ready = 1'b0;
    do_reset();
    repeat (10) edge_drive();
    chk("t2_acks", ack_cnt0, 4);
    @(negedge tb_clk);
    chk("t2_req_idle", 32'(f0.mem_req), 0);
    chk("t2_valid_full", 32'(f0.instr_valid), 1);
    for (int i = 0; i < 4; i++) q0.push_back(exp_word(16'(2 * i)));
    edge_drive();
    f0.instr_ready = 1'b1;
    @(negedge tb_clk);
    chk("t2_head0", 32'(f0.instr_pc), 32'h0000);
    chk("t2_req_full", 32'(f0.mem_req), 0);
    @(negedge tb_clk);
    chk("t2_head1", 32'(f0.instr_pc), 32'h0002);
    chk("t2_resume", {31'd0, f0.mem_req, f0.mem_addr}, 32'h0001_0004);
    drain(0, 30);

    // 3: three wait cycles per byte
    waits0 = 3;
    do_reset();
    q0.push_back(exp_word(16'h0000));
    q0.push_back(exp_word(16'h0002));
    for (int i = 0; i < 8; i++) begin
      @(negedge tb_clk);
      chk("t3_req_hold", {31'd0, f0.mem_req, f0.mem_addr},
          {16'h0001, (i < 4) ? 16'h0000 : 16'h0001});
    end
    chk("t3_valid_c7", 32'(f0.instr_valid), 0);
    @(negedge tb_clk);
    chk("t3_word_c8", {f0.instr_valid, f0.instr_pc, f0.instr_out},
        {1'b1, 32'h0000_1234});
    drain(0, 60);
    for (int i = 0; i < 4; i++)
      chk("t3_addr_seq", 32'(ack_log0[i]), i);

    // 4: redirect while the low byte is outstanding
    waits0 = 2;
    do_reset();
    repeat (3) @(negedge tb_clk);
    edge_drive();
    f0.redirect_valid = 1'b1;
    f0.redirect_pc = 16'h0100;
    q0.delete();
    q0.push_back(exp_word(16'h0100));
    q0.push_back(exp_word(16'h0102));
    @(negedge tb_clk);
    chk("t4_addr_c3", {31'd0, f0.mem_req, f0.mem_addr}, 32'h0001_0001);
    edge_drive();
    f0.redirect_valid = 1'b0;
    @(negedge tb_clk);
    chk("t4_drain_c4", {15'd0, f0.instr_valid, f0.mem_addr}, 32'h0000_0001);
    @(negedge tb_clk);
    chk("t4_drain_c5", {15'd0, f0.instr_valid, f0.mem_addr}, 32'h0000_0001);
    @(negedge tb_clk);
    chk("t4_new_c6", {15'd0, f0.instr_valid, f0.mem_addr}, 32'h0000_0100);
    drain(0, 40);

    // 5: redirect with full buffer and decoder ready
    waits0 = 0;
    f0.instr_ready = 1'b0;
    do_reset();
    repeat (8) edge_drive();
    f0.instr_ready = 1'b1;
    f0.redirect_valid = 1'b1;
    f0.redirect_pc = 16'h0201;
    q0.push_back(exp_word(16'h0201));
    q0.push_back(exp_word(16'h0203));
    @(negedge tb_clk);
    chk("t5_full", {f0.instr_valid, f0.mem_req}, 2'b10);
    edge_drive();
    f0.redirect_valid = 1'b0;
    @(negedge tb_clk);
    chk("t5_flushed", 32'(f0.instr_valid), 0);
    chk("t5_addr", {31'd0, f0.mem_req, f0.mem_addr}, 32'h0001_0201);
    drain(0, 30);

    // 6: PC wrap and reset during an outstanding request
    do_reset();
    q1.push_back(exp_word(16'hFFFF));
    q1.push_back(exp_word(16'h0001));
    @(negedge tb_clk);
    chk("t6_addr_c0", 32'(f1.mem_addr), 32'hFFFF);
    @(negedge tb_clk);
    chk("t6_addr_c1", 32'(f1.mem_addr), 32'h0000);
    @(negedge tb_clk);
    chk("t6_word_c2", {f1.instr_pc, f1.instr_out}, exp_word(16'hFFFF));
    @(negedge tb_clk);
    @(negedge tb_clk);
    chk("t6_word_c4", {f1.instr_pc, f1.instr_out}, exp_word(16'h0001));
    edge_drive();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge tb_clk);
      chk("t6_rst_outs", {f1.mem_req, f1.instr_valid, f1.instr_pc,
          f1.instr_out}, '0);
    end
    edge_drive();
    reset = 1'b0;
    q1.delete();
    q1.push_back(exp_word(16'hFFFF));
    @(negedge tb_clk);
    chk("t6_restart", {31'd0, f1.mem_req, f1.mem_addr}, 32'h0001_FFFF);
    drain(1, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
